spectrum_bar_renderer: RTL

Parametrised successor to the fixed 10-bar spectrum colour mapper. It sits between the FFT magnitude outputs and the VGA controller. Per frame it latches N bar heights, tracks a decaying peak-hold marker per bar, and produces registered RGB for each (DrawX, DrawY) through a 2-stage pixel pipeline. Snapshotting heights at frame start removes mid-frame tearing.

---
 rtl/spectrum_pkg.sv | 15 +
 rtl/peak_tracker.sv | 68 ++++++
 rtl/spectrum_bar_renderer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// Shared widths, colour constants and pixel type for the spectrum bar renderer.
package spectrum_pkg;

  localparam int HEIGHT_W = 9;

  localparam logic [23:0] BAR_RGB  = 24'hFF5500;
  localparam logic [23:0] PEAK_RGB = 24'hFFFFFF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/peak_tracker.sv
// One bar's frame-snapshotted height plus its hold-then-decay peak marker.
module peak_tracker
  import spectrum_pkg::*;
#(
  parameter int MAG_W       = 24,
  parameter int MAG_MSB     = 22,
  parameter int SCREEN_H    = 480,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic [MAG_W-1:0]    mag_i,
  output logic [HEIGHT_W-1:0] h_o,
  output logic [HEIGHT_W-1:0] peak_o
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HEIGHT_W-1:0] SCREEN_H_V = HEIGHT_W'(SCREEN_H);
  localparam logic [HEIGHT_W-1:0] DECAY_V    = HEIGHT_W'(DECAY_STEP);
  localparam logic [HOLD_W-1:0]   HOLD_V     = HOLD_W'(HOLD_FRAMES);

  logic [HEIGHT_W-1:0] h_q, h_d;
  logic [HEIGHT_W-1:0] peak_q, peak_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HEIGHT_W-1:0] slice, hn, decayed;
  logic                unused_mag;

  assign unused_mag = ^mag_i;

  always_comb begin
    slice   = mag_i[MAG_MSB -: HEIGHT_W];
    hn      = (slice > SCREEN_H_V) ? SCREEN_H_V : slice;
    // Clamp at zero so a small peak never wraps to a huge value.
    decayed = (peak_q > DECAY_V) ? (peak_q - DECAY_V) : '0;
    h_d     = h_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    if (frame_start) begin
      h_d = hn;
      if (hn >= peak_q) begin
        peak_d = hn;
        hold_d = HOLD_V;
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        peak_d = (decayed > hn) ? decayed : hn;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      h_q    <= '0;
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      h_q    <= h_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign h_o    = h_q;
  assign peak_o = peak_q;

endmodule

// File: rtl/spectrum_bar_renderer.sv
// N-bar spectrum renderer: per-frame height snapshot, peak markers, 2-stage RGB pipeline.
module spectrum_bar_renderer
  import spectrum_pkg::*;
#(
  parameter int NUM_BARS    = 10,
  parameter int MAG_W       = 24,
  parameter int MAG_MSB     = 22,
  parameter int BAR_X0      = 10,
  parameter int BAR_W       = 53,
  parameter int BAR_PITCH   = 63,
  parameter int SCREEN_H    = 480,
  parameter int PEAK_H      = 3,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic [NUM_BARS*MAG_W-1:0] mag,
  input  logic                      grad_mode,
  input  logic                      peak_en,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue
);

  localparam logic [10:0] SCREEN_H_V = 11'(SCREEN_H);
  localparam logic [10:0] PEAK_SPAN  = 11'(PEAK_H - 1);

  logic [HEIGHT_W-1:0] h_w    [NUM_BARS];
  logic [HEIGHT_W-1:0] peak_w [NUM_BARS];
  logic [NUM_BARS-1:0] in_bar;
  logic [NUM_BARS-1:0] pk;
  logic [10:0]         x_ext, y_ext;

  assign x_ext = {1'b0, DrawX};
  assign y_ext = {1'b0, DrawY};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BARS; gi++) begin : g_bar
      localparam logic [10:0] X_LO = 11'(BAR_X0 + gi * BAR_PITCH);
      localparam logic [10:0] X_HI = 11'(BAR_X0 + gi * BAR_PITCH + BAR_W);

      logic        in_span;
      logic [10:0] bar_top, pk_top;

      peak_tracker #(
        .MAG_W      (MAG_W),
        .MAG_MSB    (MAG_MSB),
        .SCREEN_H   (SCREEN_H),
        .HOLD_FRAMES(HOLD_FRAMES),
        .DECAY_STEP (DECAY_STEP)
      ) u_tracker (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .mag_i      (mag[gi*MAG_W +: MAG_W]),
        .h_o        (h_w[gi]),
        .peak_o     (peak_w[gi])
      );

      assign in_span = (x_ext >= X_LO) && (x_ext <= X_HI);
      assign bar_top = SCREEN_H_V - 11'(h_w[gi]);
      assign pk_top  = SCREEN_H_V - 11'(peak_w[gi]);
      assign in_bar[gi] = in_span && (h_w[gi] != '0) && (y_ext >= bar_top);
      // Marker rows past the bottom of the screen simply never match a visible DrawY.
      assign pk[gi] = in_span && (peak_w[gi] != '0) &&
                      (y_ext >= pk_top) && (y_ext <= pk_top + PEAK_SPAN);
    end
  endgenerate

  logic       grad_q, grad_d;
  logic       peak_en_q, peak_en_d;
  logic       s1_valid_q, s1_valid_d;
  logic       any_bar_q, any_bar_d;
  logic       any_pk_q, any_pk_d;
  logic [6:0] xcol_q, xcol_d;
  logic [7:0] yrow_q, yrow_d;
  rgb_t       rgb_q, rgb_d;

  always_comb begin
    grad_d     = frame_start ? grad_mode : grad_q;
    peak_en_d  = frame_start ? peak_en : peak_en_q;
    s1_valid_d = 1'b1;
    any_bar_d  = |in_bar;
    any_pk_d   = |pk;
    xcol_d     = DrawX[9:3];
    yrow_d     = DrawY[8:1];

    rgb_d = '0;
    // Stage 2 stays black until stage 1 has held a real pixel since reset.
    if (s1_valid_q) begin
      if (peak_en_q && any_pk_q) begin
        rgb_d = PEAK_RGB;
      end else if (any_bar_q && !grad_q) begin
        rgb_d = BAR_RGB;
      end else if (any_bar_q) begin
        rgb_d.r = 8'hFF;
        rgb_d.g = 8'hFF - yrow_q;
        rgb_d.b = 8'h00;
      end else begin
        // A 7-bit column index never exceeds 7F, so this cannot go negative.
        rgb_d.b = 8'h7F - {1'b0, xcol_q};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grad_q     <= 1'b0;
      peak_en_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      any_bar_q  <= 1'b0;
      any_pk_q   <= 1'b0;
      xcol_q     <= '0;
      yrow_q     <= '0;
      rgb_q      <= '0;
    end else begin
      grad_q     <= grad_d;
      peak_en_q  <= peak_en_d;
      s1_valid_q <= s1_valid_d;
      any_bar_q  <= any_bar_d;
      any_pk_q   <= any_pk_d;
      xcol_q     <= xcol_d;
      yrow_q     <= yrow_d;
      rgb_q      <= rgb_d;
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

endmodule
